// File: rtl/eth_rx_frame_buf.sv
// eth_rx_frame_buf: store-and-forward receive frame buffer.
// A MAC-side write port fills a circular word buffer; a frame becomes
// visible to the valid/ready read port only once its last word is written
// and its status is queued. Partial, overflowing or restarted frames are
// rolled back to the last commit point and counted as drops.
// Optional feature: define ETH_RX_BAD_FRAME_DROP_EN to drop frames whose
// status matches BAD_MASK instead of forwarding them.
module eth_rx_frame_buf #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned FRM_LOG2   = 3,
  parameter logic [7:0]  BAD_MASK   = 8'h80
) (
  input  logic                clk_app_i,
  input  logic                rst_clk_app_n,
  input  logic                rx_valid_i,
  input  logic [31:0]         rx_data_i,
  input  logic                rx_start_i,
  input  logic                rx_end_i,
  input  logic [1:0]          rx_bytesel_i,
  input  logic [7:0]          rx_status_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [31:0]         m_data_o,
  output logic                m_start_o,
  output logic                m_end_o,
  output logic [1:0]          m_bytesel_o,
  output logic [7:0]          m_status_o,
  output logic [FRM_LOG2:0]   frm_avail_o,
  output logic                drop_pulse_o,
  output logic [15:0]         drop_cnt_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned FRMS  = 1 << FRM_LOG2;

`ifdef ETH_RX_BAD_FRAME_DROP_EN
  localparam bit BAD_DROP_EN = 1'b1;
`else
  localparam bit BAD_DROP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} wr_state_t;

  typedef struct packed {
    logic        start;
    logic        last;
    logic [1:0]  bytesel;
    logic [31:0] data;
  } word_t;

  word_t       mem    [DEPTH];
  logic [7:0]  sq_mem [FRMS];

  wr_state_t            state, state_nxt;
  logic [DEPTH_LOG2:0]  wr_ptr, wr_ptr_nxt;
  logic [DEPTH_LOG2:0]  commit_ptr, commit_ptr_nxt;
  logic [DEPTH_LOG2:0]  rd_ptr;
  logic [DEPTH_LOG2:0]  base_ptr;
  logic [FRM_LOG2:0]    sq_wr, sq_rd, sq_rd_idx;

  logic        buf_full, sq_full, bad_frame;
  logic        mem_we, sq_push;
  logic [1:0]  drop_inc;
  word_t       wr_word, rd_word;
  logic        committed_pending, out_accept, out_load, status_pop;
  logic [16:0] drop_sum;

  // Pointer pair is full when the wrap bits differ and the index bits match.
  function automatic logic dptr_full(input logic [DEPTH_LOG2:0] a,
                                     input logic [DEPTH_LOG2:0] b);
    return (a[DEPTH_LOG2] != b[DEPTH_LOG2]) &&
           (a[DEPTH_LOG2-1:0] == b[DEPTH_LOG2-1:0]);
  endfunction

  // A start word always lands at the commit point, discarding any partial frame.
  assign base_ptr  = rx_start_i ? commit_ptr : wr_ptr;
  assign buf_full  = dptr_full(base_ptr, rd_ptr);
  assign sq_full   = (sq_wr[FRM_LOG2] != sq_rd[FRM_LOG2]) &&
                     (sq_wr[FRM_LOG2-1:0] == sq_rd[FRM_LOG2-1:0]);
  assign bad_frame = BAD_DROP_EN && (|(rx_status_i & BAD_MASK));
  assign wr_word   = '{start: rx_start_i, last: rx_end_i,
                       bytesel: rx_bytesel_i, data: rx_data_i};

  // Write-side next state: accept, commit, roll back or discard the incoming word.
  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    mem_we         = 1'b0;
    sq_push        = 1'b0;
    drop_inc       = 2'd0;
    if (rx_valid_i) begin
      if (rx_start_i && state == RECV) begin
        drop_inc = drop_inc + 2'd1;
      end
      if (rx_start_i || state == RECV) begin
        if (buf_full) begin
          drop_inc   = drop_inc + 2'd1;
          wr_ptr_nxt = commit_ptr;
          state_nxt  = rx_end_i ? IDLE : DISCARD;
        end else if (rx_end_i && (sq_full || bad_frame)) begin
          drop_inc   = drop_inc + 2'd1;
          wr_ptr_nxt = commit_ptr;
          state_nxt  = IDLE;
        end else begin
          mem_we     = 1'b1;
          wr_ptr_nxt = base_ptr + 1'b1;
          if (rx_end_i) begin
            commit_ptr_nxt = base_ptr + 1'b1;
            sq_push        = 1'b1;
            state_nxt      = IDLE;
          end else begin
            state_nxt = RECV;
          end
        end
      end else if (state == DISCARD && rx_end_i) begin
        state_nxt = IDLE;
      end
    end
  end

  // Write-side state, write/commit pointers and status queue write pointer.
  // NOTE: registers update with <= so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      sq_wr      <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      if (sq_push) sq_wr <= sq_wr + 1'b1;
    end
  end

  // Word buffer and status queue storage writes.
  // NOTE: storage arrays carry no reset; pointers alone define valid content, which keeps them mappable to RAM.
  always_ff @(posedge clk_app_i) begin
    if (mem_we)  mem[base_ptr[DEPTH_LOG2-1:0]] <= wr_word;
    if (sq_push) sq_mem[sq_wr[FRM_LOG2-1:0]]   <= rx_status_i;
  end

  // Read side: one output register fed from committed words only.
  assign committed_pending = (commit_ptr != rd_ptr);
  assign out_accept        = m_valid_o & m_ready_i;
  assign out_load          = committed_pending & (~m_valid_o | m_ready_i);
  assign status_pop        = out_accept & m_end_o;
  assign rd_word           = mem[rd_ptr[DEPTH_LOG2-1:0]];
  // The head status belongs to the frame in the output register; skip it if that frame completes now.
  assign sq_rd_idx         = sq_rd + {{FRM_LOG2{1'b0}}, status_pop};

  // Output register load/hold and read pointer advance.
  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      rd_ptr      <= '0;
      sq_rd       <= '0;
      m_valid_o   <= 1'b0;
      m_data_o    <= '0;
      m_start_o   <= 1'b0;
      m_end_o     <= 1'b0;
      m_bytesel_o <= '0;
      m_status_o  <= '0;
    end else begin
      if (status_pop) sq_rd <= sq_rd + 1'b1;
      if (out_load) begin
        rd_ptr      <= rd_ptr + 1'b1;
        m_valid_o   <= 1'b1;
        m_data_o    <= rd_word.data;
        m_start_o   <= rd_word.start;
        m_end_o     <= rd_word.last;
        m_bytesel_o <= rd_word.bytesel;
        m_status_o  <= rd_word.last ? sq_mem[sq_rd_idx[FRM_LOG2-1:0]] : 8'h00;
      end else if (out_accept) begin
        m_valid_o <= 1'b0;
      end
    end
  end

  // Committed frames not yet fully read equals status queue occupancy.
  assign frm_avail_o = sq_wr - sq_rd;

  assign drop_sum = {1'b0, drop_cnt_o} + {15'd0, drop_inc};

  // Drop pulse and saturating drop counter.
  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      drop_pulse_o <= 1'b0;
      drop_cnt_o   <= '0;
    end else begin
      drop_pulse_o <= (drop_inc != 2'd0);
      drop_cnt_o   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// tb_eth_rx_frame_buf: directed and randomized checks of eth_rx_frame_buf
// against a frame-level reference model (expected word queue, drop count).
module tb_eth_rx_frame_buf;

`ifdef ETH_RX_BAD_FRAME_DROP_EN
  localparam bit BAD_DROP = 1'b1;
`else
  localparam bit BAD_DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid_i, rx_start_i, rx_end_i;
  logic [31:0] rx_data_i;
  logic [1:0]  rx_bytesel_i;
  logic [7:0]  rx_status_i;
  logic        m_valid_o, m_ready_i, m_start_o, m_end_o, drop_pulse_o;
  logic [31:0] m_data_o;
  logic [1:0]  m_bytesel_o;
  logic [7:0]  m_status_o;
  logic [3:0]  frm_avail_o;
  logic [15:0] drop_cnt_o;

  logic        ready_rand = 1'b0;
  logic        ready_fix  = 1'b0;

  logic [43:0] exp_q[$];
  int          exp_drops  = 0;
  int          pulse_seen = 0;
  int          n_cmp      = 0;
  int          n_err      = 0;

  eth_rx_frame_buf #(.DEPTH_LOG2(4), .FRM_LOG2(3), .BAD_MASK(8'h80)) dut (
    .clk_app_i     (clk),
    .rst_clk_app_n (rst_n),
    .rx_valid_i    (rx_valid_i),
    .rx_data_i     (rx_data_i),
    .rx_start_i    (rx_start_i),
    .rx_end_i      (rx_end_i),
    .rx_bytesel_i  (rx_bytesel_i),
    .rx_status_i   (rx_status_i),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .m_data_o      (m_data_o),
    .m_start_o     (m_start_o),
    .m_end_o       (m_end_o),
    .m_bytesel_o   (m_bytesel_o),
    .m_status_o    (m_status_o),
    .frm_avail_o   (frm_avail_o),
    .drop_pulse_o  (drop_pulse_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output word as seen by the consumer; bytesel/status only matter on the last word.
  function automatic logic [43:0] pack(input logic s, input logic e, input logic [1:0] bs,
                                       input logic [7:0] st, input logic [31:0] d);
    return {s, e, (e ? bs : 2'd0), (e ? st : 8'h00), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic [1:0] bs,
                       input logic [7:0] st, input logic [31:0] d);
    rx_valid_i   = v;
    rx_start_i   = s;
    rx_end_i     = e;
    rx_bytesel_i = bs;
    rx_status_i  = st;
    rx_data_i    = d;
    tick();
    rx_valid_i = 1'b0;
    rx_start_i = 1'b0;
    rx_end_i   = 1'b0;
  endtask

  task automatic idle_gap(input int gap_max);
    if (gap_max > 0)
      repeat ($urandom_range(0, gap_max))
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'd0, 8'h00, 32'h0);
  endtask

  // Sends one frame, optionally preceded by 'pre' words of a frame abandoned by a restart.
  // Model: a restart drops the partial; a bad frame drops when the drop feature is built in.
  task automatic send_frame(input int len, input int pre, input logic [1:0] bs,
                            input logic [7:0] st, input int gap_max);
    logic [43:0] words[$];
    logic [31:0] d;
    logic        s, e;
    for (int i = 0; i < pre; i++) begin
      drive(1'b1, (i == 0), 1'b0, 2'd0, 8'h00, $urandom());
      idle_gap(gap_max);
    end
    for (int i = 0; i < len; i++) begin
      d = $urandom();
      s = (i == 0);
      e = (i == len - 1);
      words.push_back(pack(s, e, bs, st, d));
      drive(1'b1, s, e, bs, st, d);
      if (!e) idle_gap(gap_max);
    end
    if (pre > 0) exp_drops++;
    if (BAD_DROP && (st & 8'h80) != 8'h00) exp_drops++;
    else foreach (words[i]) exp_q.push_back(words[i]);
  endtask

  task automatic wait_drain(input string tag);
    int cyc = 0;
    while ((exp_q.size() != 0 || m_valid_o) && cyc < 3000) begin
      tick();
      cyc++;
    end
    check({tag, "_drain_done"}, (cyc < 3000), 1);
    repeat (3) tick();
    check({tag, "_frm_avail_zero"}, frm_avail_o, 0);
    check({tag, "_drop_cnt"}, drop_cnt_o, exp_drops);
    check({tag, "_drop_pulses"}, pulse_seen, exp_drops);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"},    m_valid_o, 0);
    check({tag, "_m_start_end"}, {m_start_o, m_end_o}, 0);
    check({tag, "_drop_pulse"}, drop_pulse_o, 0);
    check({tag, "_m_data"},     m_data_o, 0);
    check({tag, "_m_bs_st"},    {m_bytesel_o, m_status_o}, 0);
    check({tag, "_frm_avail"},  frm_avail_o, 0);
    check({tag, "_drop_cnt"},   drop_cnt_o, 0);
  endtask

  // Ready driver: a single process owns m_ready_i.
  initial begin
    m_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready_i = ready_rand ? ($urandom_range(0, 3) != 0) : ready_fix;
    end
  end

  // Output monitor: scoreboard compare, hold stability, drop pulse count.
  initial begin
    logic        hold_vld = 1'b0;
    logic [43:0] hold_word = '0;
    logic [43:0] raw, got;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_vld = 1'b0;
      end else begin
        raw = {m_start_o, m_end_o, m_bytesel_o, m_status_o, m_data_o};
        if (drop_pulse_o) pulse_seen++;
        if (hold_vld) check("hold_stable", {m_valid_o, raw}, {1'b1, hold_word});
        hold_vld  = m_valid_o && !m_ready_i;
        hold_word = raw;
        if (m_valid_o && m_ready_i) begin
          got = pack(m_start_o, m_end_o, m_bytesel_o, m_status_o, m_data_o);
          if (exp_q.size() == 0) check("extra_word", got, {44{1'bx}});
          else                   check("word", got, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    rx_valid_i = 1'b0; rx_start_i = 1'b0; rx_end_i = 1'b0;
    rx_data_i = '0; rx_bytesel_i = '0; rx_status_i = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 16-word frame streamed out back-to-back with ready high.
    ready_fix = 1'b1;
    tick();
    send_frame(16, 0, 2'd2, 8'h01, 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_valid_o && lat < 10);
    check("first_word_latency", (lat >= 1 && lat <= 2), 1);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check("no_gap", m_valid_o, 1);
    end
    tick();
    wait_drain("frame16");

    // Buffer overflow: 10 + 10 words into 16-word buffer with reads stalled.
    ready_fix = 1'b0;
    repeat (2) tick();
    send_frame(10, 0, 2'd3, 8'h11, 0);
    for (int i = 0; i < 10; i++)
      drive(1'b1, (i == 0), (i == 9), 2'd0, 8'h22, $urandom());
    exp_drops++;
    repeat (2) tick();
    check("ovf_frm_avail", frm_avail_o, 1);
    check("ovf_drop_cnt", drop_cnt_o, exp_drops);
    ready_fix = 1'b1;
    wait_drain("ovf");

    // Restart mid-frame: 4 words abandoned, 4-word frame from the restart word.
    send_frame(4, 4, 2'd1, 8'h05, 0);
    wait_drain("restart");

    // Status queue overflow: 9 single-word frames with reads stalled.
    ready_fix = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) send_frame(1, 0, 2'(i), 8'(i + 1), 0);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h09, $urandom());
    exp_drops++;
    repeat (2) tick();
    check("sq_frm_avail", frm_avail_o, 8);
    check("sq_drop_cnt", drop_cnt_o, exp_drops);
    ready_fix = 1'b1;
    wait_drain("sq_ovf");

    // Stray word in idle is ignored; bad-status frame follows the build option.
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 1'b1, 2'd0, 8'h80, 32'hDEAD_BEEF);
    send_frame(2, 0, 2'd3, 8'h80, 0);
    wait_drain("bad_frame");

    // Randomized batches sized to stay within buffer and queue capacity.
    ready_rand = 1'b1;
    for (int b = 0; b < 40; b++) begin
      int nfr;
      nfr = $urandom_range(1, 3);
      for (int f = 0; f < nfr; f++) begin
        if ($urandom_range(0, 4) == 0)
          drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 2'd0, 8'h00, $urandom());
        send_frame($urandom_range(1, 4), ($urandom_range(0, 3) == 0) ? 1 : 0,
                   2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0) ? (8'h80 | 8'($urandom_range(0, 127)))
                                               : 8'($urandom_range(0, 127)),
                   1);
      end
      wait_drain("random");
    end

    // Reset asserted mid-read and mid-frame.
    ready_rand = 1'b0;
    ready_fix  = 1'b0;
    repeat (2) tick();
    send_frame(3, 0, 2'd0, 8'h33, 0);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, $urandom());
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, $urandom());
    ready_fix = 1'b1;
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    exp_drops  = 0;
    pulse_seen = 0;
    repeat (2) tick();
    check_reset_outputs("midrst_hold");
    #2;
    rst_n = 1'b1;
    tick();
    send_frame(5, 0, 2'd2, 8'h44, 0);
    wait_drain("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
